packed_buffer_writer: RTL and testbench
=======================================

// Module: packed_buffer_writer
// PURPOSE
//  Sits directly downstream of the packing width converter. Takes its packed words
//  (req/ready stream) and writes each word into an on-chip buffer bank via a registered
//  valid/ready write port, generating addresses from base/stride. Each run writes a fixed
//  number of words; the block reports busy while running and pulses done when finished.
// PARAMETERS
//  DATA_WIDTH   112  packed word width; equals the upstream converter's output width
//  ADDR_WIDTH   10   buffer address width; addresses wrap modulo 2^ADDR_WIDTH
//  COUNT_WIDTH  16   width of the per-run word count
// PORTS
//  clk            in   1            single clock; all logic on posedge
//  resetn         in   1            asynchronous, active-low reset
//  cfg_start      in   1            start a run; sampled only in IDLE
//  cfg_base_addr  in   ADDR_WIDTH   first write address
//  cfg_stride     in   ADDR_WIDTH   address increment per word
//  cfg_num_words  in   COUNT_WIDTH  words in this run; 0 = empty run
//  s_write_req    in   1            upstream word valid
//  s_write_ready  out  1            block can accept a word this cycle
//  s_write_data   in   DATA_WIDTH   upstream packed word
//  buf_wr_en      out  1            buffer write valid (registered)
//  buf_wr_ready   in   1            buffer accepts the write this cycle
//  buf_wr_addr    out  ADDR_WIDTH   buffer write address (registered)
//  buf_wr_data    out  DATA_WIDTH   buffer write data (registered)
//  busy           out  1            high in every state except IDLE
//  done           out  1            one-cycle pulse at run end
//  words_written  out  COUNT_WIDTH  buffer writes completed in the current/last run
// BEHAVIOUR
//  Clock/reset: one clock; reset is asynchronous and active-low.
//  Reset (resetn=0, takes effect immediately): state=IDLE; buf_wr_en=0, buf_wr_addr=0,
//   buf_wr_data=0, busy=0, done=0, words_written=0, s_write_ready=0. A reset asserted
//   mid-run abandons the run; the pending buffer write is dropped.
//  Handshakes: an upstream word transfers when s_write_req && s_write_ready. A buffer
//   write completes when buf_wr_en && buf_wr_ready. While buf_wr_en=1 and
//   buf_wr_ready=0, buf_wr_en/addr/data stay stable.
//  Output stage: one register. slot_free = !buf_wr_en || buf_wr_ready.
//   s_write_ready = (state==RUN) && slot_free && (remaining!=0), combinational.
//  Latency: an accepted word appears on buf_wr_* the next cycle. Throughput is one word
//   per cycle while buf_wr_ready=1.
//  FSM:
//   IDLE : on cfg_start, latch base/stride/num_words; addr<=base; remaining<=num_words;
//          words_written<=0. Go to DONE if num_words==0, else RUN.
//   RUN  : per accepted word: buf_wr_data<=s_write_data; buf_wr_addr<=addr; buf_wr_en<=1;
//          addr<=addr+stride (ADDR_WIDTH bits, carry dropped); remaining<=remaining-1.
//          After accepting the word with remaining==1, go to FLUSH.
//          If a write completes and no word is accepted in the same cycle, buf_wr_en<=0.
//   FLUSH: s_write_ready=0. When !buf_wr_en, or a write completes this cycle, clear
//          buf_wr_en and go to DONE.
//   DONE : done=1 for exactly this cycle; go to IDLE.
//  busy=1 in RUN, FLUSH and DONE.
//  cfg_start is ignored outside IDLE, including in the DONE cycle.
//  words_written increments on every completed buffer write and holds its value in IDLE
//   until the next start.
//  Completing a write and accepting a new word in the same cycle loads the register with
//   the new word; no bubble is inserted.
//  Address wrap: base=2^ADDR_WIDTH-1, stride=1 gives the sequence ...,1023,0,1 for
//   ADDR_WIDTH=10.
//  Upstream words offered outside RUN are not accepted (s_write_ready=0).
// TESTING
//  T1 base=0x10, stride=1, num=4; req held high; buf_wr_ready=1 -> writes to 0x10..0x13
//     on consecutive cycles; done pulses 2 cycles after the last accept; words_written=4.
//  T2 same as T1 with buf_wr_ready=0 for 5 cycles during word 2 -> addr/data held stable;
//     s_write_ready=0; no word lost or duplicated; 4 writes total.
//  T3 base=1022, stride=3, num=3 -> addresses 1022, 1, 4 (wrap modulo 1024).
//  T4 num=0 -> busy for one cycle; done the cycle after start; no buf_wr_en;
//     s_write_ready stays 0.
//  T5 resetn pulsed low mid-run (word 2 of 8 pending) -> buf_wr_en falls immediately;
//     IDLE; no done pulse; a new start afterwards runs cleanly.
//  T6 cfg_start asserted in RUN and in the DONE cycle -> ignored; a random-stall run of
//     100 words matches a scoreboard on data and addresses.

Source files
------------

// File: rtl/packed_buffer_writer.sv
// Drains the packing converter's word stream into a buffer bank through a single
// registered write slot, generating base/stride addresses for a fixed-length run.
module packed_buffer_writer #(
    parameter int DATA_WIDTH  = 112,
    parameter int ADDR_WIDTH  = 10,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   cfg_start,
    input  logic [ADDR_WIDTH-1:0]  cfg_base_addr,
    input  logic [ADDR_WIDTH-1:0]  cfg_stride,
    input  logic [COUNT_WIDTH-1:0] cfg_num_words,
    input  logic                   s_write_req,
    output logic                   s_write_ready,
    input  logic [DATA_WIDTH-1:0]  s_write_data,
    output logic                   buf_wr_en,
    input  logic                   buf_wr_ready,
    output logic [ADDR_WIDTH-1:0]  buf_wr_addr,
    output logic [DATA_WIDTH-1:0]  buf_wr_data,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] words_written
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]  stride_q, stride_d;
    logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
    logic                   wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d;
    logic [COUNT_WIDTH-1:0] words_written_q, words_written_d;

    logic slot_free, accept, wr_done;

    // The slot can take a new word when empty or when its current write drains now.
    assign slot_free     = !wr_en_q || buf_wr_ready;
    assign wr_done       = wr_en_q && buf_wr_ready;
    assign s_write_ready = (state_q == RUN) && slot_free && (remaining_q != '0);
    assign accept        = s_write_req && s_write_ready;

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        stride_d        = stride_q;
        remaining_d     = remaining_q;
        wr_en_d         = wr_en_q;
        wr_addr_d       = wr_addr_q;
        wr_data_d       = wr_data_q;
        words_written_d = words_written_q + COUNT_WIDTH'(wr_done);

        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    addr_d          = cfg_base_addr;
                    stride_d        = cfg_stride;
                    remaining_d     = cfg_num_words;
                    words_written_d = '0;
                    state_d         = (cfg_num_words == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    wr_en_d     = 1'b1;
                    wr_addr_d   = addr_q;
                    wr_data_d   = s_write_data;
                    addr_d      = addr_q + stride_q;
                    remaining_d = remaining_q - COUNT_WIDTH'(1);
                    if (remaining_q == COUNT_WIDTH'(1)) state_d = FLUSH;
                end else if (wr_done) begin
                    wr_en_d = 1'b0;
                end
            end
            FLUSH: begin
                if (!wr_en_q || buf_wr_ready) begin
                    wr_en_d = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            stride_q        <= '0;
            remaining_q     <= '0;
            wr_en_q         <= 1'b0;
            wr_addr_q       <= '0;
            wr_data_q       <= '0;
            words_written_q <= '0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            stride_q        <= stride_d;
            remaining_q     <= remaining_d;
            wr_en_q         <= wr_en_d;
            wr_addr_q       <= wr_addr_d;
            wr_data_q       <= wr_data_d;
            words_written_q <= words_written_d;
        end
    end

    assign buf_wr_en     = wr_en_q;
    assign buf_wr_addr   = wr_addr_q;
    assign buf_wr_data   = wr_data_q;
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign words_written = words_written_q;

endmodule

// File: tb/tb_packed_buffer_writer.sv
// Directed + random-stall bench for packed_buffer_writer; accepted words go into an
// address/data scoreboard and are popped when the buffer write completes.
module tb_packed_buffer_writer;

    localparam int DW = 112;
    localparam int AW = 10;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          resetn;
    logic          cfg_start;
    logic [AW-1:0] cfg_base_addr;
    logic [AW-1:0] cfg_stride;
    logic [CW-1:0] cfg_num_words;
    logic          s_write_req;
    logic          s_write_ready;
    logic [DW-1:0] s_write_data;
    logic          buf_wr_en;
    logic          buf_wr_ready;
    logic [AW-1:0] buf_wr_addr;
    logic [DW-1:0] buf_wr_data;
    logic          busy;
    logic          done;
    logic [CW-1:0] words_written;

    packed_buffer_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .resetn(resetn), .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr),
        .cfg_stride(cfg_stride), .cfg_num_words(cfg_num_words), .s_write_req(s_write_req),
        .s_write_ready(s_write_ready), .s_write_data(s_write_data), .buf_wr_en(buf_wr_en),
        .buf_wr_ready(buf_wr_ready), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
        .busy(busy), .done(done), .words_written(words_written)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } exp_t;

    exp_t          q[$];
    int            checks = 0;
    int            errors = 0;
    int            done_cnt = 0;
    int            done_cyc = 0;
    int            run_writes = 0;
    bit            prev_stall = 0;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_data;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [127:0] w;
        w = {$urandom, $urandom, $urandom, $urandom};
        return w[DW-1:0];
    endfunction

    // Called once per cycle on the falling edge.
    task automatic observe();
        exp_t e;
        if (prev_stall) begin
            chk("hold_en", 128'(buf_wr_en), 128'(1));
            chk("hold_addr", 128'(buf_wr_addr), 128'(prev_addr));
            chk("hold_data", 128'(buf_wr_data), 128'(prev_data));
        end
        if (buf_wr_en && buf_wr_ready) begin
            run_writes++;
            if (q.size() == 0) begin
                chk("write_without_accept", 128'(buf_wr_addr), 128'(0) - 128'(1));
            end else begin
                e = q.pop_front();
                chk("wr_addr", 128'(buf_wr_addr), 128'(e.a));
                chk("wr_data", 128'(buf_wr_data), 128'(e.d));
            end
        end
        prev_stall = buf_wr_en && !buf_wr_ready;
        prev_addr  = buf_wr_addr;
        prev_data  = buf_wr_data;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    // mode 0: no stalls; 1: 5-cycle stall on word 2; 2: random stalls + stray starts;
    // 3: stop driving after two accepts (reset test continues by hand).
    task automatic run(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                       input int num, input int mode);
        logic [AW-1:0] m_addr;
        logic [DW-1:0] cur;
        int acc = 0, first_acc = 0, last_acc = 0, stall_left = 0, budget = 3000;
        int done_base;
        bit seen = 0;
        m_addr = base;
        cur = rand_word();
        done_base = done_cnt;
        run_writes = 0;
        cfg_base_addr = base;
        cfg_stride = stride;
        cfg_num_words = CW'(num);
        cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        while (!seen && budget > 0) begin
            s_write_req = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (mode == 1) begin
                buf_wr_ready = (stall_left == 0);
                if (stall_left > 0) stall_left--;
            end else if (mode == 2) begin
                buf_wr_ready = ($urandom_range(0, 2) != 0);
                cfg_start = ($urandom_range(0, 7) == 0);
                cfg_base_addr = 10'h155;
            end else begin
                buf_wr_ready = 1'b1;
            end
            s_write_data = cur;
            @(negedge clk);
            observe();
            if (done_cnt != done_base) seen = 1;
            if (mode == 1 && !buf_wr_ready && buf_wr_en)
                chk("stall_no_ready", 128'(s_write_ready), 128'(0));
            if (s_write_req && s_write_ready) begin
                q.push_back('{a: m_addr, d: cur});
                m_addr = m_addr + stride;
                acc++;
                if (acc == 1) first_acc = cyc;
                last_acc = cyc;
                cur = rand_word();
                if (mode == 1 && acc == 2) stall_left = 5;
            end
            if (mode == 2 && done) begin
                cfg_start = 1'b1;
                cfg_base_addr = 10'h2AA;
                cfg_num_words = 16'd7;
            end
            @(posedge clk); #1;
            budget--;
            if (mode == 3 && acc == 2) break;
        end
        cfg_start = 1'b0;
        if (mode == 3) return;
        s_write_req = 1'b0;
        buf_wr_ready = 1'b1;
        chk("done_seen", 128'(seen), 128'(1));
        chk("words_written", 128'(words_written), 128'(num));
        chk("write_count", 128'(run_writes), 128'(num));
        chk("sb_drained", 128'(q.size()), 128'(0));
        chk("accept_count", 128'(acc), 128'(num));
        if (mode == 0) begin
            chk("done_latency", 128'(done_cyc - last_acc), 128'(2));
            chk("accept_span", 128'(last_acc - first_acc), 128'(num - 1));
        end
        @(negedge clk);
        observe();
        chk("idle_after_run", 128'(busy), 128'(0));
    endtask

    int done_before;

    initial begin
        resetn = 1'b1;
        cfg_start = 1'b0;
        cfg_base_addr = '0;
        cfg_stride = '0;
        cfg_num_words = '0;
        s_write_req = 1'b0;
        s_write_data = '0;
        buf_wr_ready = 1'b1;
        #2 resetn = 1'b0;
        #1;
        chk("rst_wr_en", 128'(buf_wr_en), 128'(0));
        chk("rst_wr_addr", 128'(buf_wr_addr), 128'(0));
        chk("rst_wr_data", 128'(buf_wr_data), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_words", 128'(words_written), 128'(0));
        chk("rst_ready", 128'(s_write_ready), 128'(0));
        @(posedge clk); @(posedge clk); #1;
        resetn = 1'b1;
        s_write_req = 1'b1;
        @(negedge clk);
        chk("idle_no_ready", 128'(s_write_ready), 128'(0));
        @(posedge clk); #1;

        // T1 / T2 / T3
        run(10'h010, 10'd1, 4, 0);
        run(10'h010, 10'd1, 4, 1);
        run(10'd1022, 10'd3, 3, 0);
        chk("wrap_last_addr", 128'(buf_wr_addr), 128'(4));

        // T4: empty run
        done_before = done_cnt;
        run_writes = 0;
        cfg_num_words = '0;
        cfg_start = 1'b1;
        s_write_req = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        @(negedge clk);
        observe();
        chk("empty_busy", 128'(busy), 128'(1));
        chk("empty_done", 128'(done), 128'(1));
        chk("empty_ready", 128'(s_write_ready), 128'(0));
        chk("empty_wr_en", 128'(buf_wr_en), 128'(0));
        @(posedge clk); #1;
        @(negedge clk);
        observe();
        chk("empty_idle", 128'(busy), 128'(0));
        chk("empty_done_once", 128'(done_cnt - done_before), 128'(1));
        chk("empty_no_writes", 128'(run_writes), 128'(0));
        s_write_req = 1'b0;
        @(posedge clk); #1;

        // T5: reset with word 2 of 8 pending
        run(10'h040, 10'd2, 8, 3);
        buf_wr_ready = 1'b0;
        done_before = done_cnt;
        @(posedge clk); #2;
        resetn = 1'b0;
        #1;
        chk("abort_wr_en", 128'(buf_wr_en), 128'(0));
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_ready", 128'(s_write_ready), 128'(0));
        chk("abort_pending", 128'(q.size()), 128'(1));
        q.delete();
        prev_stall = 0;
        @(posedge clk); #1;
        resetn = 1'b1;
        s_write_req = 1'b0;
        buf_wr_ready = 1'b1;
        @(negedge clk);
        observe();
        chk("abort_no_done", 128'(done_cnt - done_before), 128'(0));
        chk("abort_words", 128'(words_written), 128'(0));
        @(posedge clk); #1;
        run(10'h080, 10'd5, 4, 0);

        // T6: random stalls and stray starts
        run(10'h3F0, 10'd7, 100, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
